// File: rtl/div_pkg.sv
// Shared constants and FSM state type for the iterative divider.
package div_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W     = $clog2(WIDTH_DEF);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

endpackage

// File: rtl/div_sub_stage.sv
// Trial subtraction used by each restoring-division step.
module div_sub_stage #(
    parameter int W = 17
) (
    input  logic [W-1:0] part_rem,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] diff,
    output logic         borrow
);

    logic [W:0] full;

    assign full   = {1'b0, part_rem} - {1'b0, divisor};
    assign diff   = full[W-1:0];
    assign borrow = full[W];

endmodule

// File: rtl/div_16bit.sv
// Iterative restoring divider, one quotient bit per cycle, signed or unsigned.
//   state | meaning
//   IDLE  | accepting operands
//   CALC  | one restoring step per cycle (single pass when divisor is zero)
//   DONE  | result held until consumer accepts
module div_16bit
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q, dvd_raw_q;
    logic             q_neg_q, r_neg_q, dbz_q;

    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_abs, dvs_abs;
    logic [WIDTH:0]   part_rem, diff;
    logic             borrow, last;
    logic [WIDTH-1:0] rem_nx, quo_nx;

    assign dvd_neg = is_signed & dividend[WIDTH-1];
    assign dvs_neg = is_signed & divisor[WIDTH-1];
    assign dvd_abs = dvd_neg ? -dividend : dividend;
    assign dvs_abs = dvs_neg ? -divisor : divisor;

    // Next dividend bit enters from the MSB of the quotient register.
    assign part_rem = {rem_q, quo_q[WIDTH-1]};

    div_sub_stage #(.W(WIDTH + 1)) u_sub (
        .part_rem (part_rem),
        .divisor  ({1'b0, dvs_q}),
        .diff     (diff),
        .borrow   (borrow)
    );

    assign rem_nx = borrow ? part_rem[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_nx = {quo_q[WIDTH-2:0], ~borrow};
    assign last   = (cnt_q == CNT_W'(WIDTH - 1));

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = CALC;
            CALC: if (dbz_q || last) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            dvd_raw_q   <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            dbz_q       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        quo_q     <= dvd_abs;
                        rem_q     <= '0;
                        dvs_q     <= dvs_abs;
                        dvd_raw_q <= dividend;
                        q_neg_q   <= dvd_neg ^ dvs_neg;
                        r_neg_q   <= dvd_neg;
                        dbz_q     <= (divisor == '0);
                        cnt_q     <= '0;
                    end
                end
                CALC: begin
                    if (dbz_q) begin
                        quotient    <= '1;
                        remainder   <= dvd_raw_q;
                        div_by_zero <= 1'b1;
                    end else begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last) begin
                            // Negating zero yields zero, so no separate zero check.
                            quotient    <= q_neg_q ? -quo_nx : quo_nx;
                            remainder   <= r_neg_q ? -rem_nx : rem_nx;
                            div_by_zero <= 1'b0;
                            cnt_q       <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
